// File: rtl/sumador_pkg.sv
// ============================================================================
// Module : sumador_pkg
// Brief  : Shared FSM state type and sizing helpers for the serial adder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sumador_pkg;

    typedef enum logic [1:0] {
        REPOSO  = 2'd0,
        SUMANDO = 2'd1,
        ENTREGA = 2'd2
    } estado_t;

    function automatic int ciclos(input int width, input int digitos);
        return width / digitos;
    endfunction

    // The counter must be able to represent CICLOS itself, hence the +1.
    function automatic int ancho_contador(input int width, input int digitos);
        return $clog2(ciclos(width, digitos) + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sumador_bloque.sv
// ============================================================================
// Module : sumador_bloque
// Brief  : Combinational ripple of DIGITOS full-adder cells; also exposes the
//          carry entering the top cell for signed-overflow detection.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sumador_bloque #(
    parameter int DIGITOS = 1
) (
    input  logic [DIGITOS-1:0] a,
    input  logic [DIGITOS-1:0] b,
    input  logic               cin,
    output logic [DIGITOS-1:0] s,
    output logic               cout,
    output logic               c_top
);

    // Each cell owns its carry nets so the chain is a set of distinct signals.
    for (genvar i = 0; i < DIGITOS; i++) begin : g_celda
        logic c_in;
        logic c_out;

        if (i == 0) begin : g_primero
            assign c_in = cin;
        end else begin : g_resto
            assign c_in = g_celda[i-1].c_out;
        end

        sumador_completo u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c_in),
            .cout (c_out),
            .s    (s[i])
        );
    end

    assign cout  = g_celda[DIGITOS-1].c_out;
    assign c_top = g_celda[DIGITOS-1].c_in;

endmodule

`default_nettype wire

// File: rtl/sumador_completo.sv
// ============================================================================
// Module : sumador_completo
// Brief  : Single-bit full-adder cell.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sumador_completo (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic cout,
    output logic s
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

`default_nettype wire

// File: rtl/sumador_serie_param.sv
// ============================================================================
// Module : sumador_serie_param
// Brief  : Multi-cycle adder, DIGITOS bits per clock, valid/ready handshakes
//          on operands and result; result held until consumed.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sumador_serie_param
    import sumador_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DIGITOS = 1
) (
    input  logic             reloj,
    input  logic             reset_n,
    input  logic             inicio_valido,
    output logic             listo,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             acarreo_ent,
    output logic             fin_valido,
    input  logic             fin_listo,
    output logic [WIDTH-1:0] suma,
    output logic             acarreo_sal,
    output logic             desborde
);

    if (WIDTH < 1 || DIGITOS < 1 || (WIDTH % DIGITOS) != 0) begin : g_param_error
        $error("sumador_serie_param: WIDTH must be a positive multiple of DIGITOS");
    end

    localparam int CICLOS    = ciclos(WIDTH, DIGITOS);
    localparam int ANCHO_CNT = ancho_contador(WIDTH, DIGITOS);

    estado_t                estado;
    estado_t                estado_sig;
    logic [WIDTH-1:0]       op_a;
    logic [WIDTH-1:0]       op_b;
    logic [WIDTH-1:0]       resultado;
    logic                   acarreo;
    logic [ANCHO_CNT-1:0]   contador;
    logic [DIGITOS-1:0]     tramo_suma;
    logic                   tramo_cout;
    logic                   tramo_c_top;
    logic                   aceptar;
    logic                   ultimo;

    assign listo      = (estado == REPOSO);
    assign fin_valido = (estado == ENTREGA);
    assign aceptar    = inicio_valido && listo;
    assign ultimo     = (estado == SUMANDO) && (contador == ANCHO_CNT'(CICLOS - 1));

    sumador_bloque #(
        .DIGITOS (DIGITOS)
    ) u_bloque (
        .a     (op_a[DIGITOS-1:0]),
        .b     (op_b[DIGITOS-1:0]),
        .cin   (acarreo),
        .s     (tramo_suma),
        .cout  (tramo_cout),
        .c_top (tramo_c_top)
    );

    always_ff @(posedge reloj or negedge reset_n) begin
        if (!reset_n) begin
            estado <= REPOSO;
        end else begin
            estado <= estado_sig;
        end
    end

    always_comb begin
        estado_sig = estado;
        case (estado)
            REPOSO:  if (aceptar)   estado_sig = SUMANDO;
            SUMANDO: if (ultimo)    estado_sig = ENTREGA;
            ENTREGA: if (fin_listo) estado_sig = REPOSO;
            default:                estado_sig = REPOSO;
        endcase
    end

    // Partial sums accumulate MSB-first; the final slice is merged directly
    // into the output register so only WIDTH-DIGITOS bits need storing.
    if (DIGITOS < WIDTH) begin : g_acum
        logic [WIDTH-DIGITOS-1:0] acum;

        assign resultado = {tramo_suma, acum};

        always_ff @(posedge reloj or negedge reset_n) begin
            if (!reset_n) begin
                acum <= '0;
            end else if (estado == SUMANDO) begin
                acum <= resultado[WIDTH-1:DIGITOS];
            end
        end
    end else begin : g_sin_acum
        assign resultado = tramo_suma;
    end

    always_ff @(posedge reloj or negedge reset_n) begin
        if (!reset_n) begin
            op_a        <= '0;
            op_b        <= '0;
            acarreo     <= 1'b0;
            contador    <= '0;
            suma        <= '0;
            acarreo_sal <= 1'b0;
            desborde    <= 1'b0;
        end else if (aceptar) begin
            op_a     <= a;
            op_b     <= b;
            acarreo  <= acarreo_ent;
            contador <= '0;
        end else if (estado == SUMANDO) begin
            op_a     <= op_a >> DIGITOS;
            op_b     <= op_b >> DIGITOS;
            acarreo  <= tramo_cout;
            contador <= contador + ANCHO_CNT'(1);
            if (ultimo) begin
                suma        <= resultado;
                acarreo_sal <= tramo_cout;
                desborde    <= tramo_c_top ^ tramo_cout;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sumador_serie_param.sv
// ============================================================================
// Module : tb_sumador_serie_param
// Brief  : Directed self-checking bench for sumador_serie_param.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sumador_serie_param;

    logic reloj = 1'b0;
    always #5 reloj = ~reloj;

    logic reset_n;

    logic [7:0] a8, b8;
    logic       ci8, fl8, iv1, iv4;
    logic       l1, fv1, co1, ov1;
    logic [7:0] s1;
    logic       l4, fv4, co4, ov4;
    logic [7:0] s4;

    logic [2:0] a3, b3;
    logic       ci3, iv3, fl3;
    logic       l31, fv31, co31, ov31;
    logic [2:0] s31;
    logic       l33, fv33, co33, ov33;
    logic [2:0] s33;

    int tests = 0;
    int fails = 0;

    sumador_serie_param #(.WIDTH(8), .DIGITOS(1)) u_w8d1 (
        .reloj(reloj), .reset_n(reset_n), .inicio_valido(iv1), .listo(l1),
        .a(a8), .b(b8), .acarreo_ent(ci8), .fin_valido(fv1), .fin_listo(fl8),
        .suma(s1), .acarreo_sal(co1), .desborde(ov1));

    sumador_serie_param #(.WIDTH(8), .DIGITOS(4)) u_w8d4 (
        .reloj(reloj), .reset_n(reset_n), .inicio_valido(iv4), .listo(l4),
        .a(a8), .b(b8), .acarreo_ent(ci8), .fin_valido(fv4), .fin_listo(fl8),
        .suma(s4), .acarreo_sal(co4), .desborde(ov4));

    sumador_serie_param #(.WIDTH(3), .DIGITOS(1)) u_w3d1 (
        .reloj(reloj), .reset_n(reset_n), .inicio_valido(iv3), .listo(l31),
        .a(a3), .b(b3), .acarreo_ent(ci3), .fin_valido(fv31), .fin_listo(fl3),
        .suma(s31), .acarreo_sal(co31), .desborde(ov31));

    sumador_serie_param #(.WIDTH(3), .DIGITOS(3)) u_w3d3 (
        .reloj(reloj), .reset_n(reset_n), .inicio_valido(iv3), .listo(l33),
        .a(a3), .b(b3), .acarreo_ent(ci3), .fin_valido(fv33), .fin_listo(fl3),
        .suma(s33), .acarreo_sal(co33), .desborde(ov33));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launch one 8-bit operation and count rising edges (acceptance edge = 1)
    // until fin_valido is seen; gives up after 40 edges.
    task automatic run8(input bit sel, input logic [7:0] a, input logic [7:0] b,
                        input logic c, output int edges);
        a8 = a; b8 = b; ci8 = c;
        if (sel) iv4 = 1'b1; else iv1 = 1'b1;
        @(posedge reloj);
        edges = 1;
        @(negedge reloj);
        iv1 = 1'b0; iv4 = 1'b0;
        while (((sel ? fv4 : fv1) !== 1'b1) && edges < 40) begin
            @(posedge reloj);
            edges++;
            @(negedge reloj);
        end
    endtask

    task automatic accept8();
        fl8 = 1'b1;
        @(posedge reloj);
        @(negedge reloj);
        fl8 = 1'b0;
    endtask

    initial begin
        int e;
        reset_n = 1'b0;
        a8 = '0; b8 = '0; ci8 = 1'b0; fl8 = 1'b0; iv1 = 1'b0; iv4 = 1'b0;
        a3 = '0; b3 = '0; ci3 = 1'b0; fl3 = 1'b0; iv3 = 1'b0;

        #2;
        check("rst listo", l1, 1'b1);
        check("rst fin_valido", fv1, 1'b0);
        check("rst suma", s1, 8'h00);
        check("rst acarreo/desborde", {co1, ov1}, 2'b00);
        check("rst d4 listo/valido", {l4, fv4}, 2'b10);
        @(negedge reloj);
        reset_n = 1'b1;
        @(negedge reloj);

        // 0x5A + 0x33: signed 90+51 overflows
        run8(1'b0, 8'h5A, 8'h33, 1'b0, e);
        check("t1 latency", e, 9);
        check("t1 suma", s1, 8'h8D);
        check("t1 acarreo", co1, 1'b0);
        check("t1 desborde", ov1, 1'b1);
        check("t1 listo", l1, 1'b0);
        accept8();
        check("t1 back to idle", {l1, fv1}, 2'b10);
        check("t1 suma held", s1, 8'h8D);

        run8(1'b0, 8'hFF, 8'h01, 1'b0, e);
        check("t2 suma", s1, 8'h00);
        check("t2 acarreo/desborde", {co1, ov1}, 2'b10);
        accept8();

        run8(1'b1, 8'h80, 8'h80, 1'b1, e);
        check("t3 latency", e, 3);
        check("t3 suma", s4, 8'h01);
        check("t3 acarreo/desborde", {co4, ov4}, 2'b11);
        accept8();

        run8(1'b1, 8'h5A, 8'h33, 1'b0, e);
        check("t3b latency", e, 3);
        check("t3b result", {co4, ov4, s4}, {2'b01, 8'h8D});
        accept8();

        // Backpressure with a stray start request while the result waits
        run8(1'b0, 8'h7F, 8'h01, 1'b0, e);
        check("t4 latency", e, 9);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                iv1 = 1'b1; a8 = 8'h01; b8 = 8'h01;
            end
            @(posedge reloj);
            @(negedge reloj);
            iv1 = 1'b0;
            check($sformatf("t4 hold valid %0d", i), {fv1, l1}, 2'b10);
            check($sformatf("t4 hold suma %0d", i), {co1, ov1, s1}, {2'b01, 8'h80});
        end
        accept8();
        check("t4 released", {l1, fv1}, 2'b10);
        repeat (3) @(negedge reloj);
        check("t4 stray start ignored", {l1, fv1}, 2'b10);
        check("t4 result kept", {co1, ov1, s1}, {2'b01, 8'h80});

        // Abort on the third SUMANDO cycle
        a8 = 8'h5A; b8 = 8'h33; ci8 = 1'b1; iv1 = 1'b1;
        @(posedge reloj);
        @(negedge reloj);
        iv1 = 1'b0;
        repeat (2) begin
            @(posedge reloj);
            @(negedge reloj);
        end
        check("t5 busy before reset", l1, 1'b0);
        reset_n = 1'b0;
        #1;
        check("t5 reset listo/valido", {l1, fv1}, 2'b10);
        check("t5 reset outputs", {co1, ov1, s1}, 10'd0);
        @(negedge reloj);
        reset_n = 1'b1;
        @(negedge reloj);
        run8(1'b0, 8'h0F, 8'h01, 1'b0, e);
        check("t5 latency", e, 9);
        check("t5 result", {co1, ov1, s1}, {2'b00, 8'h10});
        accept8();

        // Exhaustive 3-bit sweep on both slice widths at once
        for (int v = 0; v < 128; v++) begin
            int n;
            int u;
            int sa;
            int sb;
            int ss;
            logic ovf;
            a3 = v[6:4]; b3 = v[3:1]; ci3 = v[0];
            iv3 = 1'b1;
            @(posedge reloj);
            @(negedge reloj);
            iv3 = 1'b0;
            n = 0;
            while (!(fv31 === 1'b1 && fv33 === 1'b1) && n < 20) begin
                @(posedge reloj);
                @(negedge reloj);
                n++;
            end
            u   = int'(a3) + int'(b3) + int'(ci3);
            sa  = a3[2] ? int'(a3) - 8 : int'(a3);
            sb  = b3[2] ? int'(b3) - 8 : int'(b3);
            ss  = sa + sb + int'(ci3);
            ovf = (ss > 3) || (ss < -4);
            check($sformatf("w3d1 sum a=%0d b=%0d c=%0d", a3, b3, ci3), {co31, s31}, u);
            check($sformatf("w3d1 ovf a=%0d b=%0d c=%0d", a3, b3, ci3), ov31, ovf);
            check($sformatf("w3d3 sum a=%0d b=%0d c=%0d", a3, b3, ci3), {co33, s33}, u);
            check($sformatf("w3d3 ovf a=%0d b=%0d c=%0d", a3, b3, ci3), ov33, ovf);
            fl3 = 1'b1;
            @(posedge reloj);
            @(negedge reloj);
            fl3 = 1'b0;
        end
        check("w3 idle after sweep", {l31, l33, fv31, fv33}, 4'b1100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
